// File: rtl/seg7_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

    localparam int unsigned DEF_NUM_DIGITS = 4;
    localparam int unsigned DEF_SEG_W      = 7;

    // Callers truncate the result to their digit count.
    function automatic logic [31:0] onehot(input int unsigned index);
        return 32'd1 << index;
    endfunction

    function automatic logic phys(input logic level, input logic active_low);
        return level ^ active_low;
    endfunction

endpackage

// File: rtl/seg7_phase_cnt.sv
// Loadable phase down-counter; a loaded 0 is treated as 1 and the count never wraps.
module seg7_phase_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             done_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (load_val_i == '0) ? Width'(1) : load_val_i;
        end else if (cnt_q > Width'(1)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q <= Width'(1));

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexes a shared 7-segment bus across digit enables; new patterns
// are taken by valid/ready and swapped in only between frames.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = DEF_NUM_DIGITS,
    parameter int unsigned SEG_W          = DEF_SEG_W,
    parameter int unsigned DWELL_W        = 16,
    parameter int unsigned BLANK_W        = 8,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic                        enable_i,
    input  logic [NUM_DIGITS*SEG_W-1:0] pattern_i,
    input  logic                        pattern_valid_i,
    output logic                        pattern_ready_o,
    input  logic [DWELL_W-1:0]          dwell_i,
    input  logic [BLANK_W-1:0]          blank_i,
    output logic [SEG_W-1:0]            seg_o,
    output logic [NUM_DIGITS-1:0]       dig_o,
    output logic                        frame_done_o
);

    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PatW = NUM_DIGITS * SEG_W;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

    scan_state_e            state_q, state_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [PatW-1:0]        active_q, active_d;
    logic [PatW-1:0]        pending_q, pending_d;
    logic                   pend_full_q, pend_full_d;
    logic [SEG_W-1:0]       seg_q, seg_d;
    logic [NUM_DIGITS-1:0]  dig_q, dig_d;
    logic                   frame_done_q, frame_done_d;

    logic blank_load, blank_done;
    logic dwell_load, dwell_done;
    logic frame_end, accept, promote;
    logic [SEG_W-1:0]      seg_l;
    logic [NUM_DIGITS-1:0] dig_l;

    seg7_phase_cnt #(
        .Width(BLANK_W)
    ) u_blank_cnt (
        .clk_i     (clk_clk),
        .rst_ni    (reset_reset_n),
        .load_i    (blank_load),
        .load_val_i(blank_i),
        .done_o    (blank_done)
    );

    seg7_phase_cnt #(
        .Width(DWELL_W)
    ) u_dwell_cnt (
        .clk_i     (clk_clk),
        .rst_ni    (reset_reset_n),
        .load_i    (dwell_load),
        .load_val_i(dwell_i),
        .done_o    (dwell_done)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        blank_load = 1'b0;
        dwell_load = 1'b0;
        frame_end  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d    = BLANK;
                    idx_d      = '0;
                    blank_load = 1'b1;
                end
            end
            BLANK: begin
                if (!enable_i) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (blank_done) begin
                    state_d    = SHOW;
                    dwell_load = 1'b1;
                end
            end
            SHOW: begin
                if (!enable_i) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (dwell_done) begin
                    state_d    = BLANK;
                    blank_load = 1'b1;
                    if (idx_q == LastIdx) begin
                        idx_d     = '0;
                        frame_end = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Accept needs an empty pending slot and promotion a full one, so they never coincide.
    always_comb begin
        accept      = pattern_valid_i && !pend_full_q;
        promote     = pend_full_q && (frame_end || (state_q == IDLE));
        pending_d   = pending_q;
        pend_full_d = pend_full_q;
        active_d    = active_q;
        if (promote) begin
            active_d    = pending_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pending_d   = pattern_i;
            pend_full_d = 1'b1;
        end
    end

    // Outputs are built from next-state values so the registered pins line up with state_q.
    always_comb begin
        seg_l = '0;
        dig_l = '0;
        if (state_d == SHOW) begin
            seg_l = active_q[32'(idx_d) * SEG_W +: SEG_W];
            dig_l = NUM_DIGITS'(onehot(32'(idx_d)));
        end
        for (int i = 0; i < int'(SEG_W); i++) begin
            seg_d[i] = phys(seg_l[i], SEG_ACTIVE_LOW);
        end
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            dig_d[i] = phys(dig_l[i], DIG_ACTIVE_LOW);
        end
        frame_done_d = frame_end;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            active_q     <= '0;
            pending_q    <= '0;
            pend_full_q  <= 1'b0;
            seg_q        <= {SEG_W{SEG_ACTIVE_LOW}};
            dig_q        <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_full_q  <= pend_full_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_o           = seg_q;
    assign dig_o           = dig_q;
    assign frame_done_o    = frame_done_q;
    assign pattern_ready_o = !pend_full_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with default parameters.
module tb_seg7_scan_ctrl;

    localparam logic [27:0] PAT_A = {7'h0F, 7'h3F, 7'h5B, 7'h06};
    localparam logic [27:0] PAT_B = {7'h7F, 7'h6D, 7'h66, 7'h4F};
    localparam logic [27:0] PAT_C = {7'h07, 7'h7D, 7'h6D, 7'h66};
    localparam logic [27:0] PAT_D = {7'h77, 7'h7C, 7'h39, 7'h5E};

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        enable_i;
    logic [27:0] pattern_i;
    logic        pattern_valid_i;
    logic        pattern_ready_o;
    logic [15:0] dwell_i;
    logic [7:0]  blank_i;
    logic [6:0]  seg_o;
    logic [3:0]  dig_o;
    logic        frame_done_o;

    int n_checks = 0;
    int n_pass   = 0;

    seg7_scan_ctrl dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .enable_i       (enable_i),
        .pattern_i      (pattern_i),
        .pattern_valid_i(pattern_valid_i),
        .pattern_ready_o(pattern_ready_o),
        .dwell_i        (dwell_i),
        .blank_i        (blank_i),
        .seg_o          (seg_o),
        .dig_o          (dig_o),
        .frame_done_o   (frame_done_o)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    // Frame position p, blank cycles b, dwell cycles d (already clamped to >= 1).
    function automatic logic [3:0] exp_dig(input int p, input int b, input int d);
        int slot = b + d;
        int k    = p / slot;
        int r    = p % slot;
        if (r < b) return 4'hF;
        return ~(4'b0001 << k);
    endfunction

    function automatic logic [6:0] exp_seg(input int p, input int b, input int d,
                                           input logic [27:0] pat);
        int slot = b + d;
        int k    = p / slot;
        int r    = p % slot;
        if (r < b) return 7'h7F;
        return ~pat[k*7 +: 7];
    endfunction

    task automatic test_reset();
        reset_reset_n   = 1'b1;
        enable_i        = 1'b0;
        pattern_i       = '0;
        pattern_valid_i = 1'b0;
        dwell_i         = 16'd4;
        blank_i         = 8'd1;
        #1 reset_reset_n = 1'b0;
        #1;
        n_checks++;
        if (dig_o !== 4'hF) $display("FAIL reset_async_dig got=%h exp=%h", dig_o, 4'hF);
        else n_pass++;
        tick();
        tick();
        reset_reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (seg_o !== 7'h7F) $display("FAIL reset_seg i=%0d got=%h exp=7f", i, seg_o);
            else n_pass++;
            n_checks++;
            if (dig_o !== 4'hF) $display("FAIL reset_dig i=%0d got=%h exp=f", i, dig_o);
            else n_pass++;
            n_checks++;
            if (pattern_ready_o !== 1'b1)
                $display("FAIL reset_ready i=%0d got=%b exp=1", i, pattern_ready_o);
            else n_pass++;
            n_checks++;
            if (frame_done_o !== 1'b0)
                $display("FAIL reset_done i=%0d got=%b exp=0", i, frame_done_o);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_basic_scan();
        logic [3:0] ed;
        logic [6:0] es;
        logic       edone;
        pattern_i       = PAT_A;
        pattern_valid_i = 1'b1;
        tick();
        n_checks++;
        if (pattern_ready_o !== 1'b0) $display("FAIL idle_accept_ready got=%b exp=0", pattern_ready_o);
        else n_pass++;
        pattern_valid_i = 1'b0;
        tick();
        n_checks++;
        if (pattern_ready_o !== 1'b1) $display("FAIL idle_promote_ready got=%b exp=1", pattern_ready_o);
        else n_pass++;
        dwell_i  = 16'd4;
        blank_i  = 8'd1;
        enable_i = 1'b1;
        tick();
        for (int c = 0; c < 40; c++) begin
            ed    = exp_dig(c % 20, 1, 4);
            es    = exp_seg(c % 20, 1, 4, PAT_A);
            edone = (c % 20 == 0) && (c != 0);
            n_checks++;
            if (dig_o !== ed) $display("FAIL basic_dig cyc=%0d got=%h exp=%h", c, dig_o, ed);
            else n_pass++;
            n_checks++;
            if (seg_o !== es) $display("FAIL basic_seg cyc=%0d got=%h exp=%h", c, seg_o, es);
            else n_pass++;
            n_checks++;
            if (frame_done_o !== edone)
                $display("FAIL basic_done cyc=%0d got=%b exp=%b", c, frame_done_o, edone);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_frame_update();
        logic [3:0] ed;
        logic [6:0] es;
        logic       edone, erdy;
        for (int c = 40; c < 80; c++) begin
            ed    = exp_dig(c % 20, 1, 4);
            es    = exp_seg(c % 20, 1, 4, (c < 60) ? PAT_A : PAT_B);
            edone = (c % 20 == 0);
            erdy  = !(c >= 47 && c <= 59);
            n_checks++;
            if (dig_o !== ed) $display("FAIL update_dig cyc=%0d got=%h exp=%h", c, dig_o, ed);
            else n_pass++;
            n_checks++;
            if (seg_o !== es) $display("FAIL update_seg cyc=%0d got=%h exp=%h", c, seg_o, es);
            else n_pass++;
            n_checks++;
            if (frame_done_o !== edone)
                $display("FAIL update_done cyc=%0d got=%b exp=%b", c, frame_done_o, edone);
            else n_pass++;
            n_checks++;
            if (pattern_ready_o !== erdy)
                $display("FAIL update_ready cyc=%0d got=%b exp=%b", c, pattern_ready_o, erdy);
            else n_pass++;
            if (c == 46) begin
                pattern_i       = PAT_B;
                pattern_valid_i = 1'b1;
            end
            if (c == 47) pattern_valid_i = 1'b0;
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]  ed;
        logic [6:0]  es;
        logic [27:0] pat;
        logic        erdy;
        for (int c = 80; c < 140; c++) begin
            pat  = (c < 100) ? PAT_B : (c < 120) ? PAT_C : PAT_D;
            ed   = exp_dig(c % 20, 1, 4);
            es   = exp_seg(c % 20, 1, 4, pat);
            erdy = (c == 80) || (c == 100) || (c >= 120);
            n_checks++;
            if (dig_o !== ed) $display("FAIL bp_dig cyc=%0d got=%h exp=%h", c, dig_o, ed);
            else n_pass++;
            n_checks++;
            if (seg_o !== es) $display("FAIL bp_seg cyc=%0d got=%h exp=%h", c, seg_o, es);
            else n_pass++;
            n_checks++;
            if (pattern_ready_o !== erdy)
                $display("FAIL bp_ready cyc=%0d got=%b exp=%b", c, pattern_ready_o, erdy);
            else n_pass++;
            if (c == 80) begin
                pattern_i       = PAT_C;
                pattern_valid_i = 1'b1;
            end
            if (c == 81) pattern_i = PAT_D;
            if (c == 101) pattern_valid_i = 1'b0;
            tick();
        end
    endtask

    task automatic test_enable_drop();
        logic [3:0] ed;
        logic [6:0] es;
        logic       edone;
        for (int c = 140; c <= 152; c++) begin
            ed    = exp_dig(c % 20, 1, 4);
            es    = exp_seg(c % 20, 1, 4, PAT_D);
            edone = (c % 20 == 0);
            n_checks++;
            if (dig_o !== ed) $display("FAIL drop_dig cyc=%0d got=%h exp=%h", c, dig_o, ed);
            else n_pass++;
            n_checks++;
            if (seg_o !== es) $display("FAIL drop_seg cyc=%0d got=%h exp=%h", c, seg_o, es);
            else n_pass++;
            n_checks++;
            if (frame_done_o !== edone)
                $display("FAIL drop_done cyc=%0d got=%b exp=%b", c, frame_done_o, edone);
            else n_pass++;
            if (c != 152) tick();
        end
        enable_i = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (dig_o !== 4'hF) $display("FAIL drop_off_dig i=%0d got=%h exp=f", i, dig_o);
            else n_pass++;
            n_checks++;
            if (seg_o !== 7'h7F) $display("FAIL drop_off_seg i=%0d got=%h exp=7f", i, seg_o);
            else n_pass++;
            tick();
        end
        blank_i  = 8'd3;
        enable_i = 1'b1;
        tick();
        // Blank of 3 cycles, 4 lit cycles of digit 0, then the gap before digit 1.
        for (int p = 0; p < 8; p++) begin
            ed = exp_dig(p, 3, 4);
            es = exp_seg(p, 3, 4, PAT_D);
            n_checks++;
            if (dig_o !== ed) $display("FAIL reen_dig p=%0d got=%h exp=%h", p, dig_o, ed);
            else n_pass++;
            n_checks++;
            if (seg_o !== es) $display("FAIL reen_seg p=%0d got=%h exp=%h", p, seg_o, es);
            else n_pass++;
            if (p != 7) tick();
        end
    endtask

    task automatic test_min_phase();
        logic [3:0] ed;
        logic [6:0] es;
        logic       edone;
        enable_i = 1'b0;
        tick();
        n_checks++;
        if (dig_o !== 4'hF) $display("FAIL min_idle_dig got=%h exp=f", dig_o);
        else n_pass++;
        dwell_i  = 16'd0;
        blank_i  = 8'd0;
        enable_i = 1'b1;
        tick();
        for (int c = 0; c < 24; c++) begin
            ed    = exp_dig(c % 8, 1, 1);
            es    = exp_seg(c % 8, 1, 1, PAT_D);
            edone = (c % 8 == 0) && (c != 0);
            n_checks++;
            if (dig_o !== ed) $display("FAIL min_dig cyc=%0d got=%h exp=%h", c, dig_o, ed);
            else n_pass++;
            n_checks++;
            if (seg_o !== es) $display("FAIL min_seg cyc=%0d got=%h exp=%h", c, seg_o, es);
            else n_pass++;
            n_checks++;
            if (frame_done_o !== edone)
                $display("FAIL min_done cyc=%0d got=%b exp=%b", c, frame_done_o, edone);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        pattern_i       = PAT_A;
        pattern_valid_i = 1'b1;
        tick();
        pattern_valid_i = 1'b0;
        n_checks++;
        if (pattern_ready_o !== 1'b0) $display("FAIL rst_pend_ready got=%b exp=0", pattern_ready_o);
        else n_pass++;
        n_checks++;
        if (dig_o !== 4'hE) $display("FAIL rst_pre_dig got=%h exp=e", dig_o);
        else n_pass++;
        #2 reset_reset_n = 1'b0;
        #1;
        n_checks++;
        if (dig_o !== 4'hF) $display("FAIL rst_mid_dig got=%h exp=f", dig_o);
        else n_pass++;
        n_checks++;
        if (seg_o !== 7'h7F) $display("FAIL rst_mid_seg got=%h exp=7f", seg_o);
        else n_pass++;
        n_checks++;
        if (pattern_ready_o !== 1'b1) $display("FAIL rst_mid_ready got=%b exp=1", pattern_ready_o);
        else n_pass++;
        tick();
        reset_reset_n = 1'b1;
        tick();
        n_checks++;
        if (dig_o !== 4'hF) $display("FAIL rst_blank_dig got=%h exp=f", dig_o);
        else n_pass++;
        tick();
        // Pending pattern was discarded, so the active pattern is still all dark.
        n_checks++;
        if (dig_o !== 4'hE) $display("FAIL rst_show_dig got=%h exp=e", dig_o);
        else n_pass++;
        n_checks++;
        if (seg_o !== 7'h7F) $display("FAIL rst_show_seg got=%h exp=7f", seg_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_frame_update();
        test_backpressure();
        test_enable_drop();
        test_min_phase();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
